// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : filter_pkg
//  Brief    : Shared encodings for the WOS filter job controller.
//  Revision : 1.0  initial release
// ============================================================================
package filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] CFG_ADDR_CTRL = 2'd0;
    localparam logic [1:0] CFG_ADDR_H    = 2'd1;
    localparam logic [1:0] CFG_ADDR_W    = 2'd2;
    localparam logic [1:0] CFG_ADDR_N    = 2'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQCLR = 2;

    localparam int STATUS_IRQ  = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;
    localparam int STATUS_BUSY = 3;
    localparam int STATUS_TMO  = 4;

endpackage
`default_nettype wire

// File: rtl/filter_cfg_check.sv
`default_nettype none
// ============================================================================
//  Module   : filter_cfg_check
//  Brief    : Combinational image-config validity check and registered h*w.
//  Revision : 1.0  initial release
// ============================================================================
module filter_cfg_check #(
    parameter int WORD  = 8,
    parameter int MAX_N = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD-1:0]   i_h,
    input  logic [WORD-1:0]   i_w,
    input  logic [WORD-1:0]   i_n,
    output logic              o_valid,
    output logic [2*WORD-1:0] o_total
);

    localparam logic [2*WORD-1:0] PROD_MAX = (2*WORD)'(1) << (WORD + 1);

    logic [2*WORD-1:0] w_prod;

    assign w_prod = (2*WORD)'(i_h) * (2*WORD)'(i_w);

    // An odd n is necessarily non-zero, so n[0] also covers n >= 1.
    assign o_valid = i_n[0] && (i_n <= WORD'(MAX_N)) && (i_h >= i_n) &&
                     (i_w >= i_n) && (w_prod <= PROD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_total <= '0;
        end else begin
            o_total <= w_prod;
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : filter_job_ctrl
//  Brief    : Job sequencer for the WOS filter address generator.
//             Optional watchdog enabled by defining FILTER_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module filter_job_ctrl
    import filter_pkg::*;
#(
    parameter int WORD      = 8,
    parameter int MAX_N     = 25,
`ifdef FILTER_TIMEOUT_EN
    parameter int TMO_CYC   = 4096,
`endif
    parameter int DRAIN_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [WORD-1:0] cfg_wdata,
    output logic [WORD-1:0] cfg_rdata,
    output logic [WORD-1:0] h,
    output logic [WORD-1:0] w,
    output logic [WORD-1:0] n,
    output logic            run,
    input  logic            gen_w_en,
    input  logic            gen_newline,
    output logic [WORD-1:0] row_cnt,
    output logic            busy,
    output logic            irq
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t              r_state, w_next;
    logic                r_done, r_err;
    logic [2*WORD-1:0]   r_pix_cnt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic [2*WORD-1:0]   w_total;
    logic                w_valid, w_ctrl_wr, w_start, w_abort, w_irq_clr;
    logic                w_last, w_drain_end, w_tmo, w_tmo_flag, w_go;
    logic                w_enter_err, w_enter_done;

    filter_cfg_check #(
        .WORD   (WORD),
        .MAX_N  (MAX_N)
    ) u_cfg_check (
        .clk     (clk),
        .rst     (rst),
        .i_h     (h),
        .i_w     (w),
        .i_n     (n),
        .o_valid (w_valid),
        .o_total (w_total)
    );

    assign w_ctrl_wr    = cfg_we && (cfg_addr == CFG_ADDR_CTRL);
    assign w_abort      = w_ctrl_wr && cfg_wdata[CTRL_ABORT];
    assign w_start      = w_ctrl_wr && cfg_wdata[CTRL_START] && !cfg_wdata[CTRL_ABORT];
    assign w_irq_clr    = w_ctrl_wr && cfg_wdata[CTRL_IRQCLR];
    assign busy         = (r_state == ST_CHECK) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign run          = (r_state == ST_RUN);
    assign w_go         = w_start && !busy;
    assign w_last       = gen_w_en && (r_pix_cnt == w_total - (2*WORD)'(1));
    assign w_drain_end  = (r_drain_cnt == DRAIN_W'(DRAIN_CYC - 1));
    assign w_enter_err  = (w_next == ST_ERR) && (r_state != ST_ERR);
    assign w_enter_done = (w_next == ST_DONE) && (r_state == ST_DRAIN);

`ifdef FILTER_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    logic [TMO_W-1:0] r_wdog;
    logic             r_tmo;

    // Held at zero outside RUN, so entry to RUN always starts a fresh window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_tmo  <= 1'b0;
        end else begin
            r_wdog <= (r_state != ST_RUN || gen_w_en) ? '0 : r_wdog + TMO_W'(1);
            if (w_go) begin
                r_tmo <= 1'b0;
            end else if (w_enter_err && r_state == ST_RUN) begin
                r_tmo <= 1'b1;
            end
        end
    end

    assign w_tmo      = !gen_w_en && (r_wdog == TMO_W'(TMO_CYC - 1));
    assign w_tmo_flag = r_tmo;
`else
    assign w_tmo      = 1'b0;
    assign w_tmo_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (w_start) w_next = ST_CHECK;
            ST_CHECK: w_next = w_valid ? ST_RUN : ST_ERR;
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DRAIN;
                end else if (w_tmo) begin
                    w_next = ST_ERR;
                end
            end
            ST_DRAIN: if (w_drain_end) w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
        if (w_abort && busy) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h           <= '0;
            w           <= '0;
            n           <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            irq         <= 1'b0;
            r_pix_cnt   <= '0;
            row_cnt     <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (cfg_we && !busy) begin
                case (cfg_addr)
                    CFG_ADDR_H: h <= cfg_wdata;
                    CFG_ADDR_W: w <= cfg_wdata;
                    CFG_ADDR_N: n <= cfg_wdata;
                    default: ;
                endcase
            end
            if (w_go) begin
                r_done    <= 1'b0;
                r_err     <= 1'b0;
                r_pix_cnt <= '0;
                row_cnt   <= '0;
            end
            if (w_enter_err) r_err <= 1'b1;
            if (w_enter_done) r_done <= 1'b1;
            // A new event outranks a simultaneous clear so it is never lost.
            if (w_enter_err || w_enter_done) begin
                irq <= 1'b1;
            end else if (w_irq_clr) begin
                irq <= 1'b0;
            end
            if (r_state == ST_RUN) begin
                if (gen_w_en) r_pix_cnt <= r_pix_cnt + (2*WORD)'(1);
                if (gen_newline && row_cnt != '1) row_cnt <= row_cnt + WORD'(1);
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_ADDR_CTRL: begin
                cfg_rdata[STATUS_IRQ]  = irq;
                cfg_rdata[STATUS_DONE] = r_done;
                cfg_rdata[STATUS_ERR]  = r_err;
                cfg_rdata[STATUS_BUSY] = busy;
                cfg_rdata[STATUS_TMO]  = w_tmo_flag;
            end
            CFG_ADDR_H: cfg_rdata = h;
            CFG_ADDR_W: cfg_rdata = w;
            CFG_ADDR_N: cfg_rdata = n;
            default: cfg_rdata = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_filter_job_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_filter_job_ctrl
//  Brief    : Randomized self-checking bench for filter_job_ctrl (WORD=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_filter_job_ctrl;
    import filter_pkg::*;

    localparam int DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [7:0] cfg_rdata, h, w, n, row_cnt;
    logic       run, busy, irq;
    logic       gen_w_en = 1'b0;
    logic       gen_newline = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    filter_job_ctrl #(
        .WORD      (8),
`ifdef FILTER_TIMEOUT_EN
        .TMO_CYC   (16),
`endif
        .DRAIN_CYC (DRAIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .h           (h),
        .w           (w),
        .n           (n),
        .run         (run),
        .gen_w_en    (gen_w_en),
        .gen_newline (gen_newline),
        .row_cnt     (row_cnt),
        .busy        (busy),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0; cfg_wdata = 8'd0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    // Reference rules for a legal job, in plain integer arithmetic.
    function automatic bit cfg_ok(input int hh, input int ww, input int nn);
        return (nn % 2 == 1) && nn >= 1 && nn <= 25 && hh >= nn && ww >= nn && hh * ww <= 512;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic run_job(input int hh, input int ww, input int nn,
                           input bit nl_all, input bit clr_at_done, input int abort_at);
        int total, nl, bad_run;
        logic [7:0] d;
        cfg_write(CFG_ADDR_CTRL, 8'h04);
        cfg_write(CFG_ADDR_H, 8'(hh));
        cfg_write(CFG_ADDR_W, 8'(ww));
        cfg_write(CFG_ADDR_N, 8'(nn));
        total = hh * ww;
        cfg_write(CFG_ADDR_CTRL, 8'h01);
        check("check_cycle", {30'd0, busy, run}, 32'h2);
        step();
        if (!cfg_ok(hh, ww, nn)) begin
            check("err_run", run, 0);
            rd(CFG_ADDR_CTRL, d);
            check("err_status", d, 32'h05);
            return;
        end
        check("run_rise", run, 1);
        nl = 0;
        bad_run = 0;
        for (int k = 0; k < total; k++) begin
            if (k == abort_at) begin
                cfg_write(CFG_ADDR_CTRL, 8'h02);
                check("abort_run", {30'd0, busy, run}, 32'h0);
                check("abort_pix", dut.r_pix_cnt, abort_at);
                check("abort_rows", row_cnt, sat(nl));
                rd(CFG_ADDR_CTRL, d);
                check("abort_status", d, 32'h00);
                return;
            end
            if (k == 3) begin
                cfg_write(CFG_ADDR_H, 8'd5);
                rd(CFG_ADDR_H, d);
                check("h_locked", d, hh);
                if (!run) bad_run++;
            end
            repeat ($urandom_range(0, 2)) begin
                gen_newline = (!nl_all && $urandom_range(0, 7) == 0);
                if (gen_newline) nl++;
                step();
                gen_newline = 1'b0;
                if (!run) bad_run++;
            end
            gen_w_en = 1'b1;
            gen_newline = nl_all || ($urandom_range(0, 3) == 0);
            if (gen_newline) nl++;
            step();
            gen_w_en = 1'b0;
            gen_newline = 1'b0;
            if (k < total - 1 && !run) bad_run++;
        end
        check("run_held", bad_run, 0);
        check("run_fall", {30'd0, busy, run}, 32'h2);
        for (int i = 1; i <= DRAIN; i++) begin
            if (i == DRAIN && clr_at_done) cfg_write(CFG_ADDR_CTRL, 8'h04);
            else step();
            if (i < DRAIN) begin
                rd(CFG_ADDR_CTRL, d);
                check("drain_status", d, 32'h08);
            end
        end
        rd(CFG_ADDR_CTRL, d);
        check("done_status", d, 32'h03);
        check("done_irq", irq, 1);
        check("done_rows", row_cnt, sat(nl));
        gen_newline = 1'b1;
        step();
        gen_newline = 1'b0;
        check("rows_outside_run", row_cnt, sat(nl));
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) step();
        rst = 1'b0;
        rd(CFG_ADDR_CTRL, d);
        check("rst_status", d, 32'h00);
        rd(CFG_ADDR_H, d);
        check("rst_h", d, 0);
        check("rst_outs", {h, w, n, row_cnt, 4'd0, run, busy, irq, 1'b0}, 32'h0);

        cfg_write(CFG_ADDR_CTRL, 8'h03);
        check("start_abort_idle", {30'd0, busy, run}, 32'h0);

        run_job(8, 8, 3, 1'b0, 1'b0, -1);
        run_job(8, 8, 4, 1'b0, 1'b0, -1);
        run_job(2, 8, 3, 1'b0, 1'b0, -1);
        run_job(16, 32, 15, 1'b1, 1'b1, -1);
        cfg_write(CFG_ADDR_CTRL, 8'h04);
        check("irq_clr", irq, 0);
        run_job(17, 32, 3, 1'b0, 1'b0, -1);
        run_job(30, 15, 27, 1'b0, 1'b0, -1);
        run_job(25, 20, 25, 1'b0, 1'b0, -1);
        run_job(8, 8, 3, 1'b0, 1'b0, 10);

        cfg_write(CFG_ADDR_CTRL, 8'h04);
        cfg_write(CFG_ADDR_H, 8'd8);
        cfg_write(CFG_ADDR_W, 8'd8);
        cfg_write(CFG_ADDR_N, 8'd3);
        cfg_write(CFG_ADDR_CTRL, 8'h01);
        step();
`ifdef FILTER_TIMEOUT_EN
        repeat (15) step();
        check("tmo_pending", run, 1);
        step();
        check("tmo_run", run, 0);
        rd(CFG_ADDR_CTRL, d);
        check("tmo_status", d, 32'h15);
`else
        repeat (100) step();
        check("no_tmo_run", run, 1);
        cfg_write(CFG_ADDR_CTRL, 8'h02);
        check("no_tmo_abort", busy, 0);
`endif

        cfg_write(CFG_ADDR_CTRL, 8'h01);
        step();
        repeat (3) begin
            gen_w_en = 1'b1; gen_newline = 1'b1;
            step();
        end
        gen_w_en = 1'b0; gen_newline = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd(CFG_ADDR_H, d);
        check("midrst_h", d, 0);
        check("midrst_outs", {row_cnt, run, busy, irq}, 32'h0);

        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 27),
                    1'b0, 1'(j % 2), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
